// File: rtl/video_timing_monitor_if.sv
// Raster bundle from the core's video output toward the timing monitor.
//   ce_pix  pixel enable; the other signals are meaningful only when it is 1
//   hsync   active-high horizontal sync
//   hblank  active-high horizontal blank
//   vsync   active-high vertical sync
//   vblank  active-high vertical blank
//   video   8-bit pixel value
// master drives the raster (core or bench); slave observes it (monitor).
interface video_timing_monitor_if;
    logic       ce_pix;
    logic       hsync;
    logic       hblank;
    logic       vsync;
    logic       vblank;
    logic [7:0] video;

    modport master (output ce_pix, hsync, hblank, vsync, vblank, video);
    modport slave  (input  ce_pix, hsync, hblank, vsync, vblank, video);
endinterface

// File: rtl/video_timing_monitor.sv
// Sink-side raster monitor. Measures line/frame geometry, HSync width and a
// per-frame active-pixel checksum, and declares lock once two consecutive
// published frames have identical geometry.
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   vin        raster inputs (slave side of video_timing_monitor_if)
//   h_total    ce_pix cycles per line (HSync rise to rise)
//   h_active   active pixels on the last line that had any
//   hs_width   ce_pix cycles with hsync=1 on the last line
//   v_total    lines per frame (HSync rises between VSync rises)
//   v_active   lines holding at least one active pixel
//   pix_sum    sum of video over active pixels of the last frame, mod 2^SUMW
//   frame_done 1-clk pulse when results update
//   locked     geometry stable over two consecutive frames
//   overflow   sticky: some counter saturated; cleared by reset only
//
// state    | meaning
// SEARCH   | no reference geometry yet (after reset or saturation)
// MEASURE  | snapshot held, waiting for a frame that repeats it
// LOCKED   | last published geometry equals the snapshot
module video_timing_monitor #(
    parameter int CW   = 10,
    parameter int SUMW = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    video_timing_monitor_if.slave   vin,
    output logic [CW-1:0]           h_total,
    output logic [CW-1:0]           h_active,
    output logic [CW-1:0]           hs_width,
    output logic [CW-1:0]           v_total,
    output logic [CW-1:0]           v_active,
    output logic [SUMW-1:0]         pix_sum,
    output logic                    frame_done,
    output logic                    locked,
    output logic                    overflow
);

    typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_LOCKED} state_t;

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    state_t          state;
    logic            prev_hsync;
    logic            prev_vsync;
    logic            vs_seen;
    logic [CW-1:0]   lc;
    logic [CW-1:0]   act_cnt;
    logic [CW-1:0]   hsw_cnt;
    logic [CW-1:0]   line_cnt;
    logic [CW-1:0]   vact_cnt;
    logic [SUMW-1:0] sum_cnt;
    logic [CW-1:0]   cur_h_total;
    logic [CW-1:0]   cur_h_active;
    logic [CW-1:0]   cur_hs_width;
    logic [5*CW-1:0] snap;

    logic            hrise;
    logic            vrise;
    logic            pix_act;
    logic            line_had_act;
    logic            sat;
    logic [SUMW-1:0] pix_val;
    logic [CW-1:0]   h_total_nxt;
    logic [CW-1:0]   h_active_nxt;
    logic [CW-1:0]   hs_width_nxt;
    logic [CW-1:0]   line_nxt;
    logic [CW-1:0]   vact_nxt;
    logic [5*CW-1:0] geom_nxt;

    // The HSync-rise pixel is pixel 0 of the new line, so the closing line's
    // values come from the counters as they stand before this pixel. When
    // HSync and VSync rise together, the line is folded into the *_nxt values
    // first and the frame is published from those.
    always_comb begin
        hrise        = vin.ce_pix & vin.hsync & ~prev_hsync;
        vrise        = vin.ce_pix & vin.vsync & ~prev_vsync;
        pix_act      = ~vin.hblank & ~vin.vblank;
        line_had_act = (act_cnt != '0);
        pix_val      = pix_act ? {{(SUMW-8){1'b0}}, vin.video} : '0;
        h_total_nxt  = cur_h_total;
        h_active_nxt = cur_h_active;
        hs_width_nxt = cur_hs_width;
        line_nxt     = line_cnt;
        vact_nxt     = vact_cnt;
        if (hrise) begin
            h_total_nxt  = sat_inc(lc);
            hs_width_nxt = hsw_cnt;
            line_nxt     = sat_inc(line_cnt);
            if (line_had_act) begin
                h_active_nxt = act_cnt;
                vact_nxt     = sat_inc(vact_cnt);
            end
        end
        geom_nxt = {h_total_nxt, h_active_nxt, hs_width_nxt, line_nxt, vact_nxt};
        sat = vin.ce_pix & ((lc == CNT_MAX)
                          | (~hrise & pix_act & (act_cnt == CNT_MAX))
                          | (~hrise & vin.hsync & (hsw_cnt == CNT_MAX))
                          | (hrise & (line_cnt == CNT_MAX))
                          | (hrise & line_had_act & (vact_cnt == CNT_MAX)));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_SEARCH;
            prev_hsync   <= 1'b0;
            prev_vsync   <= 1'b0;
            vs_seen      <= 1'b0;
            lc           <= '0;
            act_cnt      <= '0;
            hsw_cnt      <= '0;
            line_cnt     <= '0;
            vact_cnt     <= '0;
            sum_cnt      <= '0;
            cur_h_total  <= '0;
            cur_h_active <= '0;
            cur_hs_width <= '0;
            snap         <= '0;
            h_total      <= '0;
            h_active     <= '0;
            hs_width     <= '0;
            v_total      <= '0;
            v_active     <= '0;
            pix_sum      <= '0;
            frame_done   <= 1'b0;
            locked       <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (vin.ce_pix) begin
                prev_hsync <= vin.hsync;
                prev_vsync <= vin.vsync;

                if (hrise) begin
                    lc           <= '0;
                    act_cnt      <= {{(CW-1){1'b0}}, pix_act};
                    hsw_cnt      <= CNT_ONE;
                    cur_h_total  <= h_total_nxt;
                    cur_h_active <= h_active_nxt;
                    cur_hs_width <= hs_width_nxt;
                end else begin
                    lc <= sat_inc(lc);
                    if (pix_act)   act_cnt <= sat_inc(act_cnt);
                    if (vin.hsync) hsw_cnt <= sat_inc(hsw_cnt);
                end

                if (vrise) begin
                    line_cnt <= '0;
                    vact_cnt <= '0;
                    sum_cnt  <= pix_val;
                    vs_seen  <= 1'b1;
                    // The first VSync after reset only opens a frame.
                    if (vs_seen) begin
                        h_total    <= h_total_nxt;
                        h_active   <= h_active_nxt;
                        hs_width   <= hs_width_nxt;
                        v_total    <= line_nxt;
                        v_active   <= vact_nxt;
                        pix_sum    <= sum_cnt;
                        frame_done <= 1'b1;
                        case (state)
                            ST_SEARCH: begin
                                state  <= ST_MEASURE;
                                snap   <= geom_nxt;
                                locked <= 1'b0;
                            end
                            ST_MEASURE: begin
                                if (geom_nxt == snap) begin
                                    state  <= ST_LOCKED;
                                    locked <= 1'b1;
                                end else begin
                                    snap <= geom_nxt;
                                end
                            end
                            ST_LOCKED: begin
                                if (geom_nxt != snap) begin
                                    state  <= ST_MEASURE;
                                    snap   <= geom_nxt;
                                    locked <= 1'b0;
                                end
                            end
                            default: begin
                                state  <= ST_SEARCH;
                                locked <= 1'b0;
                            end
                        endcase
                    end
                end else begin
                    line_cnt <= line_nxt;
                    vact_cnt <= vact_nxt;
                    sum_cnt  <= sum_cnt + pix_val;
                end

                // Saturation overrides any lock decision taken this cycle.
                if (sat) begin
                    overflow <= 1'b1;
                    state    <= ST_SEARCH;
                    locked   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_video_timing_monitor.sv
module tb_video_timing_monitor;

    logic        clk;
    logic        reset_n;
    logic [9:0]  h_total, h_active, hs_width, v_total, v_active;
    logic [15:0] pix_sum;
    logic        frame_done, locked, overflow;

    video_timing_monitor_if vif();

    video_timing_monitor #(.CW(10), .SUMW(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .vin        (vif.slave),
        .h_total    (h_total),
        .h_active   (h_active),
        .hs_width   (hs_width),
        .v_total    (v_total),
        .v_active   (v_active),
        .pix_sum    (pix_sum),
        .frame_done (frame_done),
        .locked     (locked),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int done_cnt   = 0;

    // Counts clocks with frame_done high; a stretched pulse shows up as an
    // extra count against the per-frame expectation.
    always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

    task automatic chk(input string name, input int got, input int exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    typedef struct {
        int ht, hact, hsw, vt, vact;
        int vid;
        bit tog;
        int e_ht, e_hact, e_hsw, e_vt, e_vact, e_sum, e_lock, e_done;
    } vec_t;

    function automatic vec_t mk(int ht, int hact, int hsw, int vt, int vact, int vid, bit tog,
                                int e_ht, int e_hact, int e_hsw, int e_vt, int e_vact,
                                int e_sum, int e_lock, int e_done);
        vec_t v;
        v.ht = ht; v.hact = hact; v.hsw = hsw; v.vt = vt; v.vact = vact;
        v.vid = vid; v.tog = tog;
        v.e_ht = e_ht; v.e_hact = e_hact; v.e_hsw = e_hsw; v.e_vt = e_vt;
        v.e_vact = e_vact; v.e_sum = e_sum; v.e_lock = e_lock; v.e_done = e_done;
        return v;
    endfunction

    // One raster frame: HSync on x<hsw, active x<hact and y<vact, VSync on the
    // last three lines so its rise coincides with an HSync rise.
    task automatic gen_frame(input int ht, input int hact, input int hsw, input int vt,
                             input int vact, input int vid, input bit tog);
        for (int y = 0; y < vt; y++) begin
            for (int x = 0; x < ht; x++) begin
                if (tog) begin
                    vif.ce_pix = 1'b0;
                    @(posedge clk); #1;
                end
                vif.ce_pix = 1'b1;
                vif.hsync  = (x < hsw);
                vif.hblank = (x >= hact);
                vif.vsync  = (y >= vt - 3);
                vif.vblank = (y >= vact);
                vif.video  = 8'(vid);
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " h_total"},    int'(h_total), 0);
        chk({tag, " h_active"},   int'(h_active), 0);
        chk({tag, " hs_width"},   int'(hs_width), 0);
        chk({tag, " v_total"},    int'(v_total), 0);
        chk({tag, " v_active"},   int'(v_active), 0);
        chk({tag, " pix_sum"},    int'(pix_sum), 0);
        chk({tag, " frame_done"}, int'(frame_done), 0);
        chk({tag, " locked"},     int'(locked), 0);
        chk({tag, " overflow"},   int'(overflow), 0);
    endtask

    vec_t tbl[8];

    initial begin
        int d0;
        // A: 50x16, active 40x10, hs 6.  B: 50x20, active 40x12, hs 6.
        // pix_sum = hact*vact*vid mod 65536 (40*10*255 = 102000 -> 36464).
        tbl[0] = mk(50,40,6,16,10, 8'hFF, 0,  0, 0,0, 0, 0,     0, 0, 0);
        tbl[1] = mk(50,40,6,16,10, 8'hFF, 0, 50,40,6,16,10, 36464, 0, 1);
        tbl[2] = mk(50,40,6,16,10, 8'hFF, 0, 50,40,6,16,10, 36464, 1, 1);
        tbl[3] = mk(50,40,6,16,10, 8'h01, 0, 50,40,6,16,10,   400, 1, 1);
        tbl[4] = mk(50,40,6,20,12, 8'h01, 0, 50,40,6,20,12,   480, 0, 1);
        tbl[5] = mk(50,40,6,20,12, 8'h03, 0, 50,40,6,20,12,  1440, 1, 1);
        tbl[6] = mk(50,40,6,20,12, 8'h03, 1, 50,40,6,20,12,  1440, 1, 1);
        tbl[7] = mk(50,40,6,20,12, 8'h80, 1, 50,40,6,20,12, 61440, 1, 1);

        reset_n    = 1'b0;
        vif.ce_pix = 1'b0;
        vif.hsync  = 1'b0;
        vif.hblank = 1'b0;
        vif.vsync  = 1'b0;
        vif.vblank = 1'b0;
        vif.video  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            d0 = done_cnt;
            gen_frame(tbl[i].ht, tbl[i].hact, tbl[i].hsw, tbl[i].vt, tbl[i].vact,
                      tbl[i].vid, tbl[i].tog);
            chk($sformatf("v%0d h_total", i),  int'(h_total),  tbl[i].e_ht);
            chk($sformatf("v%0d h_active", i), int'(h_active), tbl[i].e_hact);
            chk($sformatf("v%0d hs_width", i), int'(hs_width), tbl[i].e_hsw);
            chk($sformatf("v%0d v_total", i),  int'(v_total),  tbl[i].e_vt);
            chk($sformatf("v%0d v_active", i), int'(v_active), tbl[i].e_vact);
            chk($sformatf("v%0d pix_sum", i),  int'(pix_sum),  tbl[i].e_sum);
            chk($sformatf("v%0d locked", i),   int'(locked),   tbl[i].e_lock);
            chk($sformatf("v%0d done_clks", i), done_cnt - d0, tbl[i].e_done);
            chk($sformatf("v%0d overflow", i), int'(overflow), 0);
        end

        // HSync starved: line counter saturates, overflow sticks, lock lost.
        vif.ce_pix = 1'b1;
        vif.hsync  = 1'b0;
        vif.vsync  = 1'b0;
        vif.hblank = 1'b1;
        vif.vblank = 1'b1;
        repeat (1100) begin
            @(posedge clk); #1;
        end
        chk("sat overflow", int'(overflow), 1);
        chk("sat locked",   int'(locked),   0);
        // HSync and VSync rise together: the saturated line closes the frame.
        vif.hsync = 1'b1;
        vif.vsync = 1'b1;
        @(posedge clk); #1;
        chk("sat frame_done lat1", int'(frame_done), 1);
        chk("sat h_total",         int'(h_total),    1023);
        chk("sat locked after",    int'(locked),     0);
        @(posedge clk); #1;
        chk("sat frame_done width", int'(frame_done), 0);

        // Reset asserted mid-frame.
        gen_frame(50,40,6,16,10, 8'hFF, 0);
        gen_frame(50,40,6,16,10, 8'hFF, 0);
        chk("pre-reset h_total", int'(h_total), 50);
        for (int x = 0; x < 120; x++) begin
            vif.hsync  = ((x % 50) < 6);
            vif.hblank = ((x % 50) >= 40);
            vif.vsync  = 1'b0;
            vif.vblank = 1'b0;
            @(posedge clk); #1;
        end
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("midreset");
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        d0 = done_cnt;
        gen_frame(50,40,6,16,10, 8'hFF, 0);
        chk("post-reset first done_clks", done_cnt - d0, 0);
        chk("post-reset first h_total",   int'(h_total), 0);
        d0 = done_cnt;
        gen_frame(50,40,6,16,10, 8'hFF, 0);
        chk("post-reset second done_clks", done_cnt - d0, 1);
        chk("post-reset v_total",  int'(v_total), 16);
        chk("post-reset pix_sum",  int'(pix_sum), 36464);
        chk("post-reset overflow", int'(overflow), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
